// File: rtl/xor_ram_ctrl.sv
// Command sequencer for the dual-bank XOR bit RAM: two valid/ready channels, 2-cycle response latency.
// Full throughput per channel; ready drops for clear sweeps and same-address A/B collisions (A wins).
module xor_ram_ctrl #(
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_a,
  output logic                  cmd_ready_a,
  input  logic [1:0]            cmd_op_a,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_a,
  output logic                  rsp_valid_a,
  output logic                  rsp_data_a,
  input  logic                  cmd_valid_b,
  output logic                  cmd_ready_b,
  input  logic [1:0]            cmd_op_b,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
  output logic                  rsp_valid_b,
  output logic                  rsp_data_b,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  ram_rst,
  output logic                  ram_wr_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  input  logic                  ram_q_a,
  output logic                  ram_wr_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic                  ram_q_b
);

  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_DRAIN} state_t;

  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_SET  = 2'd1;
  localparam logic [1:0] OP_CLR  = 2'd2;
  localparam logic [1:0] OP_FLIP = 2'd3;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ctr;
  logic                  r_clear_done;

  logic                  r_s1_vld_a, r_s1_vld_b;
  logic [1:0]            r_s1_op_a, r_s1_op_b;
  logic [ADDR_WIDTH-1:0] r_s1_addr_a, r_s1_addr_b;
  logic                  r_rsp_vld_a, r_rsp_vld_b;
  logic                  r_rsp_dat_a, r_rsp_dat_b;

  logic                  w_run;
  logic                  w_acc_a, w_acc_b;
  logic                  w_sweep_end;

  // Toggle needed so the stored bit ends up at the op's target value.
  function automatic logic f_toggle(input logic [1:0] op, input logic q);
    case (op)
      OP_READ: f_toggle = 1'b0;
      OP_SET:  f_toggle = ~q;
      OP_CLR:  f_toggle = q;
      OP_FLIP: f_toggle = 1'b1;
      default: f_toggle = 1'b0;
    endcase
  endfunction

  assign w_run       = (r_state == ST_RUN);
  assign w_sweep_end = (r_state == ST_CLEAR) && (r_ctr == LAST_ADDR);
  assign cmd_ready_a = w_run & ~clear_req;
  assign cmd_ready_b = cmd_ready_a & ~(cmd_valid_a & (cmd_addr_a == cmd_addr_b));
  assign w_acc_a     = cmd_valid_a & cmd_ready_a;
  assign w_acc_b     = cmd_valid_b & cmd_ready_b;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (w_sweep_end) w_state_nxt = ST_RUN;
      ST_RUN:   if (clear_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_s1_vld_a && !r_s1_vld_b) w_state_nxt = ST_CLEAR;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_CLEAR;
      r_ctr        <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clear_done <= w_sweep_end;
      if (r_state == ST_CLEAR && !w_sweep_end) r_ctr <= r_ctr + 1'b1;
      else                                     r_ctr <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld_a  <= 1'b0;
      r_s1_op_a   <= OP_READ;
      r_s1_addr_a <= '0;
      r_s1_vld_b  <= 1'b0;
      r_s1_op_b   <= OP_READ;
      r_s1_addr_b <= '0;
      r_rsp_vld_a <= 1'b0;
      r_rsp_dat_a <= 1'b0;
      r_rsp_vld_b <= 1'b0;
      r_rsp_dat_b <= 1'b0;
    end else begin
      r_s1_vld_a  <= w_acc_a;
      r_s1_vld_b  <= w_acc_b;
      if (w_acc_a) begin
        r_s1_op_a   <= cmd_op_a;
        r_s1_addr_a <= cmd_addr_a;
      end
      if (w_acc_b) begin
        r_s1_op_b   <= cmd_op_b;
        r_s1_addr_b <= cmd_addr_b;
      end
      r_rsp_vld_a <= r_s1_vld_a;
      r_rsp_dat_a <= r_s1_vld_a & ram_q_a;
      r_rsp_vld_b <= r_s1_vld_b;
      r_rsp_dat_b <= r_s1_vld_b & ram_q_b;
    end
  end

  // S1 is always empty during the sweep, so the address mux never steals a live op.
  assign ram_rst     = (r_state == ST_CLEAR);
  assign ram_addr_a  = ram_rst ? r_ctr : r_s1_addr_a;
  assign ram_addr_b  = ram_rst ? r_ctr : r_s1_addr_b;
  assign ram_wr_a    = r_s1_vld_a & f_toggle(r_s1_op_a, ram_q_a);
  assign ram_wr_b    = r_s1_vld_b & f_toggle(r_s1_op_b, ram_q_b);

  assign busy        = ~w_run;
  assign clear_done  = r_clear_done;
  assign rsp_valid_a = r_rsp_vld_a;
  assign rsp_data_a  = r_rsp_dat_a;
  assign rsp_valid_b = r_rsp_vld_b;
  assign rsp_data_b  = r_rsp_dat_b;

endmodule
